axi4_slave_mem: RTL

- AXI4 full-protocol responder with internal word-addressed memory.
- Completion partner for the team's AXI4 burst masters: accepts their write/read bursts as a synthesizable target in place of the DDR/HP-port path, for block designs and in-system loopback.
- Independent write and read engines; one outstanding transaction per direction.

---
 rtl/axi4_slave_mem_if.sv | 46 ++++
 rtl/axi4_slave_mem.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_mem_if.sv
// axi4_slave_mem_if: AXI4 write/read channel bundle between a burst master and axi4_slave_mem
interface axi4_slave_mem_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 6
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 burst target backed by word-addressed memory; AXI4_SLAVE_MEM_STATS_EN adds beat/error counters
module axi4_slave_mem #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 6
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi4_slave_mem_if.slave  s_axi
`ifdef AXI4_SLAVE_MEM_STATS_EN
  ,
  output logic [31:0]      wr_beat_count,
  output logic [31:0]      rd_beat_count,
  output logic [15:0]      err_count
`endif
);
  localparam int SH = $clog2(DATA_WIDTH/8);
  localparam int WA = ADDR_WIDTH - SH;
  localparam int NB = DATA_WIDTH/8;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  logic [DATA_WIDTH-1:0] mem [1<<WA];
  logic                  live_q;
  w_state_t              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [WA-1:0]         w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic                  w_fixed_q, w_fixed_d, w_err_q, w_err_d;
  r_state_t              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [WA-1:0]         r_addr_q, r_addr_d, r_next, ar_word;
  logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic                  r_fixed_q, r_fixed_d, r_err_q, r_err_d, r_last_q, r_last_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_err, ar_err;
  assign aw_hs  = s_axi.awvalid & s_axi.awready;
  assign w_hs   = s_axi.wvalid & s_axi.wready;
  assign b_hs   = s_axi.bvalid & s_axi.bready;
  assign ar_hs  = s_axi.arvalid & s_axi.arready;
  assign r_hs   = s_axi.rvalid & s_axi.rready;
  assign aw_err = s_axi.awburst[1] | (s_axi.awsize != 3'(SH));
  assign ar_err = s_axi.arburst[1] | (s_axi.arsize != 3'(SH));
  assign ar_word = WA'(s_axi.araddr >> SH);
  assign r_next  = r_fixed_q ? r_addr_q : r_addr_q + 1'b1;
  assign s_axi.awready = live_q & (w_state_q == W_IDLE);
  assign s_axi.wready  = w_state_q == W_DATA;
  assign s_axi.bvalid  = w_state_q == W_RESP;
  assign s_axi.bid     = w_id_q;
  assign s_axi.bresp   = {w_err_q, 1'b0};
  assign s_axi.arready = live_q & (r_state_q == R_IDLE);
  assign s_axi.rvalid  = r_state_q == R_DATA;
  assign s_axi.rid     = r_id_q;
  assign s_axi.rdata   = r_data_q;
  assign s_axi.rresp   = {r_err_q, 1'b0};
  assign s_axi.rlast   = r_last_q;
  // keeps both ready outputs low while in reset and for the first cycle after release
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) live_q <= 1'b0;
    else live_q <= 1'b1;
  // write engine registers
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_fixed_q <= w_fixed_d;
      w_err_q   <= w_err_d;
    end
  // write engine next state: latch AW, step address per beat, flag wlast/len disagreement
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_fixed_d = w_fixed_q;
    w_err_d   = w_err_q;
    if (aw_hs) begin
      w_state_d = W_DATA;
      w_id_d    = s_axi.awid;
      w_addr_d  = WA'(s_axi.awaddr >> SH);
      w_len_d   = s_axi.awlen;
      w_cnt_d   = '0;
      w_fixed_d = s_axi.awburst == 2'b00;
      w_err_d   = aw_err;
    end
    if (w_hs) begin
      w_cnt_d   = w_cnt_q + 8'd1;
      w_addr_d  = w_fixed_q ? w_addr_q : w_addr_q + 1'b1;
      w_err_d   = w_err_q | (s_axi.wlast != (w_cnt_q == w_len_q));
      w_state_d = s_axi.wlast ? W_RESP : W_DATA;
    end
    if (b_hs) w_state_d = W_IDLE;
  end
  // byte-lane write port; contents survive reset
  always_ff @(posedge aclk)
    if (w_hs && !w_err_q)
      for (int i = 0; i < NB; i++)
        if (s_axi.wstrb[i]) mem[w_addr_q][8*i +: 8] <= s_axi.wdata[8*i +: 8];
  // read engine registers
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_fixed_q <= 1'b0;
      r_err_q   <= 1'b0;
      r_last_q  <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_fixed_q <= r_fixed_d;
      r_err_q   <= r_err_d;
      r_last_q  <= r_last_d;
      r_data_q  <= r_data_d;
    end
  // read engine next state: prefetch the next word on each accepted beat for 1 beat/cycle
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_fixed_d = r_fixed_q;
    r_err_d   = r_err_q;
    r_last_d  = r_last_q;
    r_data_d  = r_data_q;
    if (ar_hs) begin
      r_state_d = R_DATA;
      r_id_d    = s_axi.arid;
      r_addr_d  = ar_word;
      r_len_d   = s_axi.arlen;
      r_cnt_d   = '0;
      r_fixed_d = s_axi.arburst == 2'b00;
      r_err_d   = ar_err;
      r_last_d  = s_axi.arlen == 8'd0;
      r_data_d  = ar_err ? '0 : mem[ar_word];
    end else if (r_hs && r_last_q) begin
      r_state_d = R_IDLE;
      r_last_d  = 1'b0;
    end else if (r_hs) begin
      r_cnt_d   = r_cnt_q + 8'd1;
      r_addr_d  = r_next;
      r_last_d  = (r_cnt_q + 8'd1) == r_len_q;
      r_data_d  = r_err_q ? '0 : mem[r_next];
    end
  end
`ifdef AXI4_SLAVE_MEM_STATS_EN
  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  assign err_inc = 2'(b_hs & w_err_q) + 2'(r_hs & r_last_q & r_err_q);
  assign err_sum = {1'b0, err_count} + 17'(err_inc);
  // saturating activity counters
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wr_beat_count <= '0;
      rd_beat_count <= '0;
      err_count     <= '0;
    end else begin
      if (w_hs && !(&wr_beat_count)) wr_beat_count <= wr_beat_count + 32'd1;
      if (r_hs && !(&rd_beat_count)) rd_beat_count <= rd_beat_count + 32'd1;
      err_count <= err_sum[16] ? '1 : err_sum[15:0];
    end
`endif
endmodule
